// File: rtl/mdu_issue_ctrl.sv
// Issue-side controller for the multiply/divide unit: owns the E-stage MDU op
// register and a shadow occupancy model that stalls MDU-class ops in D.
module mdu_issue_ctrl #(
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] D_MDUtype,
  input  logic       ext_stall,
  input  logic       MDU_busy,
  output logic [3:0] E_MDUtype,
  output logic       stall_mdu,
  output logic       shadow_busy,
  output logic [3:0] shadow_cnt,
  output logic       busy_mismatch
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2
  } state_e;

  state_e     state_q, state_d;
  logic [3:0] e_type_q, e_type_d;
  logic [3:0] cnt_q, cnt_d;
  logic       busy_q, busy_d;
  logic       mismatch_q, mismatch_d;

  logic d_mdu, e_start, e_long, stall;

  assign d_mdu   = (D_MDUtype >= 4'd1) && (D_MDUtype <= 4'd8);
  assign e_start = (e_type_q >= 4'd1) && (e_type_q <= 4'd4);
  assign e_long  = (e_type_q == 4'd3) || (e_type_q == 4'd4);
  assign stall   = d_mdu && (e_start || busy_q);

  // E-stage register next state: bubble on any stall, squash unused encodings.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    e_type_d = D_MDUtype;
    if (stall || ext_stall) begin
      e_type_d = 4'd0;
    end else if (D_MDUtype > 4'd8) begin
      e_type_d = 4'd0;
    end
  end

  // Shadow occupancy FSM. A start seen while busy is ignored, as the MDU does.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (e_start) begin
          state_d = e_long ? DIV : MULT;
          cnt_d   = e_long ? 4'(DIV_LAT) : 4'(MULT_LAT);
          busy_d  = 1'b1;
        end else begin
          cnt_d  = 4'd0;
          busy_d = 1'b0;
        end
      end
      MULT, DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          busy_d  = 1'b0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign mismatch_d = mismatch_q | (MDU_busy != busy_q);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state_q    <= IDLE;
      e_type_q   <= 4'd0;
      cnt_q      <= 4'd0;
      busy_q     <= 1'b0;
      mismatch_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      e_type_q   <= e_type_d;
      cnt_q      <= cnt_d;
      busy_q     <= busy_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign E_MDUtype     = e_type_q;
  assign stall_mdu     = stall;
  assign shadow_busy   = busy_q;
  assign shadow_cnt    = cnt_q;
  assign busy_mismatch = mismatch_q;

endmodule

// File: tb/tb_mdu_issue_ctrl.sv
// Scoreboard bench for mdu_issue_ctrl: directed per-cycle vectors push their
// hand-computed expected outputs; a negedge monitor pops and compares.
module tb_mdu_issue_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] D_MDUtype;
  logic       ext_stall;
  logic       MDU_busy;
  logic [3:0] E_MDUtype;
  logic       stall_mdu;
  logic       shadow_busy;
  logic [3:0] shadow_cnt;
  logic       busy_mismatch;

  mdu_issue_ctrl #(.MULT_LAT(5), .DIV_LAT(10)) dut (
    .clk          (clk),
    .reset        (reset),
    .D_MDUtype    (D_MDUtype),
    .ext_stall    (ext_stall),
    .MDU_busy     (MDU_busy),
    .E_MDUtype    (E_MDUtype),
    .stall_mdu    (stall_mdu),
    .shadow_busy  (shadow_busy),
    .shadow_cnt   (shadow_cnt),
    .busy_mismatch(busy_mismatch)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] e;
    logic       s;
    logic       b;
    logic [3:0] c;
    logic       m;
    string      tag;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  bit   stim_done = 1'b0;

  // Monitor: one comparison per cycle that has an expectation queued.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      total++;
      if (E_MDUtype !== x.e || stall_mdu !== x.s || shadow_busy !== x.b ||
          shadow_cnt !== x.c || busy_mismatch !== x.m) begin
        bad++;
        $display("FAIL %s: got E=%0d stall=%0b busy=%0b cnt=%0d mm=%0b, want E=%0d stall=%0b busy=%0b cnt=%0d mm=%0b",
                 x.tag, E_MDUtype, stall_mdu, shadow_busy, shadow_cnt, busy_mismatch,
                 x.e, x.s, x.b, x.c, x.m);
      end
    end
  end

  // Drive one cycle of inputs and queue that cycle's expected outputs.
  task automatic step(input logic [3:0] d, input logic ext, input logic mb,
                      input logic [3:0] e, input logic s, input logic b,
                      input logic [3:0] c, input logic m, input string tag);
    exp_t x;
    D_MDUtype = d;
    ext_stall = ext;
    MDU_busy  = mb;
    x.e = e; x.s = s; x.b = b; x.c = c; x.m = m; x.tag = tag;
    sb.push_back(x);
    @(posedge clk);
    #1;
  endtask

  // n busy cycles with counter counting down from c0, E holding a bubble.
  task automatic busy_run(input logic [3:0] d, input int n, input logic [3:0] c0,
                          input logic s, input logic m, input string tag);
    for (int i = 0; i < n; i++) begin
      step(d, 1'b0, 1'b1, 4'd0, s, 1'b1, c0 - 4'(i), m, tag);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    D_MDUtype = 4'd0;
    ext_stall = 1'b0;
    MDU_busy  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    do_reset();

    // Idle after reset.
    for (int i = 0; i < 20; i++) step(4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "idle");
    step(4'd12, 0, 0, 4'd0, 0, 0, 4'd0, 0, "illegal_op_d");
    step(4'd0,  0, 0, 4'd0, 0, 0, 4'd0, 0, "illegal_op_e");

    // mult then mfhi: stall cycles 1..6, mfhi in E at cycle 8.
    step(4'd1, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mult_c0");
    step(4'd5, 0, 0, 4'd1, 1, 0, 4'd0, 0, "mult_c1");
    busy_run(4'd5, 5, 4'd5, 1, 0, "mult_busy");
    step(4'd5, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mult_c7");
    step(4'd0, 0, 0, 4'd5, 0, 0, 4'd0, 0, "mfhi_in_e");
    step(4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mfhi_no_start");

    // divu then mflo: stall cycles 1..11, cnt starts at 10.
    step(4'd4, 0, 0, 4'd0, 0, 0, 4'd0, 0, "divu_c0");
    step(4'd6, 0, 0, 4'd4, 1, 0, 4'd0, 0, "divu_c1");
    busy_run(4'd6, 10, 4'd10, 1, 0, "divu_busy");
    step(4'd6, 0, 0, 4'd0, 0, 0, 4'd0, 0, "divu_c12");
    step(4'd0, 0, 0, 4'd6, 0, 0, 4'd0, 0, "mflo_in_e");

    // mult followed by add-class ops: never stalled, ext_stall only bubbles.
    step(4'd1, 0, 0, 4'd0, 0, 0, 4'd0, 0, "add_c0");
    step(4'd0, 0, 0, 4'd1, 0, 0, 4'd0, 0, "add_c1");
    step(4'd0, 0, 1, 4'd0, 0, 1, 4'd5, 0, "add_c2");
    step(4'd0, 1, 1, 4'd0, 0, 1, 4'd4, 0, "add_c3_ext");
    step(4'd0, 0, 1, 4'd0, 0, 1, 4'd3, 0, "add_c4");
    step(4'd0, 0, 1, 4'd0, 0, 1, 4'd2, 0, "add_c5");
    step(4'd0, 0, 1, 4'd0, 0, 1, 4'd1, 0, "add_c6");
    step(4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "add_c7");

    // ext_stall with mthi in D and idle shadow.
    step(4'd7, 1, 0, 4'd0, 0, 0, 4'd0, 0, "mthi_ext");
    step(4'd7, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mthi_bubbled");
    step(4'd0, 0, 0, 4'd7, 0, 0, 4'd0, 0, "mthi_in_e");
    step(4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mthi_no_start");

    // mult behind mult, with ext_stall coinciding with stall_mdu.
    step(4'd1, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mm_c0");
    step(4'd1, 0, 0, 4'd1, 1, 0, 4'd0, 0, "mm_c1");
    step(4'd1, 0, 1, 4'd0, 1, 1, 4'd5, 0, "mm_c2");
    step(4'd1, 1, 1, 4'd0, 1, 1, 4'd4, 0, "mm_c3_ext");
    busy_run(4'd1, 3, 4'd3, 1, 0, "mm_busy");
    step(4'd1, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mm_c7");
    step(4'd0, 0, 0, 4'd1, 0, 0, 4'd0, 0, "mm_c8");
    busy_run(4'd0, 5, 4'd5, 0, 0, "mm_second");
    step(4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mm_done");

    // MDU_busy one cycle early: sticky mismatch, cleared by mid-run reset.
    step(4'd1, 0, 0, 4'd0, 0, 0, 4'd0, 0, "mm_err_c0");
    step(4'd0, 0, 1, 4'd1, 0, 0, 4'd0, 0, "mm_err_early");
    busy_run(4'd0, 2, 4'd5, 0, 1, "mm_err_sticky");
    do_reset();
    step(4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "post_reset");
    step(4'd0, 0, 0, 4'd0, 0, 0, 4'd0, 0, "post_reset2");

    stim_done = 1'b1;
  end

  initial begin
    wait (stim_done);
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    #1;
    if (sb.size() > 0) begin
      bad++;
      $display("FAIL drain: %0d expectations unchecked, want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mdu_issue_ctrl.md
Name: mdu_issue_ctrl

Overview:
- Issue-side partner of the multiply/divide unit (MDU).
- Sits at the D→E boundary and owns the E-stage MDUtype pipeline register that drives the MDU.
- Keeps a shadow model of MDU occupancy, which it uses to stall any MDU-class instruction in D until HI/LO are safe to use.
- Cross-checks its shadow model against the MDU's real busy output and raises a sticky error flag on disagreement.

Parameters:
- MULT_LAT, 5: busy cycles after mult/multu issue. Range 1..15.
- DIV_LAT, 10: busy cycles after div/divu issue. Range 1..15.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- D_MDUtype  in  4  MDU op of the instruction in D. Encoding: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo. Values 9..15 are treated as 0.
- ext_stall  in  1  D-stage stall requested by other hazard logic.
- MDU_busy  in  1  busy output of the MDU, used for the cross-check only.
- E_MDUtype  out  4  registered op driven to the MDU's MDUtype input.
- stall_mdu  out  1  combinational; freezes PC/F/D and bubbles E.
- shadow_busy  out  1  registered model of MDU busy.
- shadow_cnt  out  4  registered remaining-cycle counter.
- busy_mismatch  out  1  sticky error flag.

Behaviour:
- Reset: E_MDUtype=0, shadow_busy=0, shadow_cnt=0, state=IDLE, busy_mismatch=0.
  - Reset mid-operation abandons the shadow count immediately.
  - The MDU is reset by the same signal, so the two stay consistent.
- Decode helpers:
  - D_mdu = D_MDUtype in 1..8.
  - E_start = E_MDUtype in 1..4.
  - E_long = E_MDUtype in 3..4.
- stall_mdu = D_mdu && (E_start || shadow_busy). This is purely combinational, with no added latency.
- E register, updated each edge:
  - If reset: 0.
  - Else if stall_mdu or ext_stall: 0 (bubble).
  - Else D_MDUtype, with 9..15 mapped to 0.
- Shadow FSM, states IDLE / MULT / DIV:
  - IDLE: if E_start, load shadow_cnt = E_long ? DIV_LAT : MULT_LAT, go to DIV or MULT, set shadow_busy=1. Otherwise stay in IDLE with cnt=0.
  - MULT/DIV: if shadow_cnt==1, go to IDLE, cnt=0, busy=0 (the same edge on which the MDU commits HI/LO). Otherwise cnt decrements by 1.
  - shadow_busy is high for exactly MULT_LAT / DIV_LAT cycles, starting the cycle after the E_start cycle.
- E_start while shadow_busy=1 cannot occur under correct stalling. If it does occur, the shadow ignores it, matching the MDU, which ignores starts when its counter is non-zero.
- mthi/mtlo/mfhi/mflo in E never affect the shadow FSM.
- Cross-check: on every non-reset edge, if MDU_busy != shadow_busy then busy_mismatch <= 1. The flag stays set until reset.
- Net stall: an MDU-class op in D directly behind an issuing mult is held for 1 + MULT_LAT cycles, and for 1 + DIV_LAT cycles behind div.
- Non-MDU instructions are never stalled by this block.
- Simultaneous events:
  - ext_stall with stall_mdu: bubble once, no double effect.
  - D op that is itself mult, arriving while shadow busy: stalled like any other MDU op.
  - The final busy cycle (cnt==1) still stalls. The D op is released the following cycle and sees the committed HI/LO in E.

Test Plan:
- Reset, then idle: all outputs 0 and busy_mismatch stays 0 for 20 cycles with MDU_busy=0.
- mult in D at cycle 0, then mfhi in D from cycle 1:
  - E_MDUtype=1 in cycle 1.
  - shadow_busy high cycles 2..6, cnt 5,4,3,2,1.
  - stall_mdu high cycles 1..6 (6 cycles).
  - mfhi reaches E in cycle 8 with E_MDUtype=5.
- divu then mflo (same timing as above): stall_mdu high for 11 cycles and shadow_cnt starts at 10.
- mult followed by add-class ops (D_MDUtype=0): stall_mdu never asserts and E_MDUtype shows 0 bubbles only when ext_stall=1.
- ext_stall=1 for one cycle with D_MDUtype=7 and idle shadow: E gets 0 that cycle, and mthi (7) enters E on the next edge.
- Drive MDU_busy=1 one cycle early relative to shadow_busy: busy_mismatch rises on that edge, stays 1 until reset, and clears on reset.
